ifetch_axi_master: RTL and testbench
====================================

# ifetch_axi_master

Single-outstanding AXI4 read master that sits directly downstream of the IF stage: it consumes the 14-bit word address the IF stage presents to instruction memory, fetches the 32-bit instruction over the AXI read channels, and returns it with a one-cycle valid pulse. Until the instruction returns, it holds the pipeline with a stall signal. It is the CPU's only path to instruction memory on the AXI bus.

## Interface
- `ID_WIDTH`, 4: ARID/RID width.
- `ADDR_WIDTH`, 32: ARADDR width.
- `DATA_WIDTH`, 32: RDATA width; must be 32.
- `BASE_ADDR`, 32'h0000_0000: byte base of instruction memory on the bus.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_word`  in  14  word address from IF (`pc_to_iram`).
- `fetch_req`  in  1  IF requests the instruction at `pc_word`.
- `if_flush`  in  1  discard any in-flight fetch.
- `inst`  out  32  fetched instruction; held until the next valid.
- `inst_valid`  out  1  one-cycle pulse when `inst` is updated.
- `inst_err`  out  1  one-cycle pulse with `inst_valid` when RRESP != OKAY.
- `fetch_stall`  out  1  `fetch_req & ~inst_valid` (combinational).
- `ARID`  out  ID_WIDTH  constant 0.
- `ARADDR`  out  ADDR_WIDTH  `BASE_ADDR + {pc_word, 2'b00}`, latched.
- `ARLEN`, `ARSIZE`, `ARBURST`  out  4, 3, 2  constants 0, 3'b010, 2'b01.
- `ARVALID`  out  1; `ARREADY`  in  1.
- `RID`  in  ID_WIDTH; `RDATA`  in  32; `RRESP`  in  2; `RLAST`  in  1; `RVALID`  in  1; `RREADY`  out  1.

## Operation
- The FSM has three states: IDLE, ADDR and DATA.
- **IDLE**
  - If `fetch_req & ~if_flush`, latch ARADDR and go to ADDR.
  - If `if_flush` is high in the same cycle, the request is ignored for that cycle.
- **ADDR**
  - `ARVALID` is 1.
  - ARADDR is stable while waiting.
  - On `ARVALID & ARREADY`, go to DATA.
- **DATA**
  - `RREADY` is 1.
  - On `RVALID & RREADY`, return to IDLE.
  - Unless the drop flag is set, register the instruction and pulse `inst_valid` the next cycle:
    - RRESP == 2'b00: `inst <= RDATA`.
    - Otherwise: `inst <= 32'h0000_0013` (NOP) and `inst_err` pulses.
  - RLAST is expected to be 1. RID is not checked.
- **Flush**
  - `if_flush` in ADDR or DATA sets the drop flag.
  - The AR handshake is not withdrawn; the transaction completes on the bus.
  - The returned data is discarded: no `inst_valid`, `inst` unchanged.
  - The drop flag clears on return to IDLE.
- **Request contract**
  - IF holds `pc_word` and `fetch_req` stable while `fetch_stall` is 1.
  - Changes mid-fetch (other than through `if_flush`) are ignored. The latched address is used.
- **Reset**
  - Reset values: state IDLE; ARVALID=0, RREADY=0, inst=32'h0000_0013, inst_valid=0, inst_err=0; drop flag 0; ARADDR=BASE_ADDR.
  - Reset mid-transaction abandons the transaction. The whole system resets together, so this is acceptable.

## Timing
- Cycle N: `fetch_req` sampled in IDLE.
- Cycle N+1: `ARVALID`=1.
- With ARREADY at N+1 and RVALID at N+2, `inst_valid` is high at N+3. Minimum miss latency is 3 cycles.
- Each extra ARREADY or RVALID wait cycle adds one cycle.
- `fetch_stall` is high from N through N+2 and falls combinationally at N+3.
- The next request can be accepted in the cycle after `inst_valid` (IDLE again).
- At most one transaction is outstanding, so back-to-back fetches cost at least 4 cycles each.

## Configuration
- `IFETCH_BUF_EN` defined: adds a one-entry buffer holding last-address, last-instruction and valid.
  - In IDLE, a request with `fetch_req & ~if_flush` and `pc_word` equal to the buffered address and valid set issues no AR.
  - `inst_valid` pulses at N+1 with the buffered instruction.
  - The buffer is filled on every non-dropped OKAY response.
  - It is cleared by reset only; error responses do not fill it.
- Undefined: no buffer, and every request goes to the bus.

## Test plan
- **Basic fetch:** pc_word=14'h0004, ARREADY=1, RVALID at N+2 with RDATA=32'h0010_0093 -> ARADDR=32'h0000_0010, ARLEN=0, ARSIZE=2, inst=32'h0010_0093, inst_valid one cycle at N+3.
- **Backpressure:** ARREADY low for 3 cycles, RVALID late by 2 cycles -> ARVALID/ARADDR stable throughout, `fetch_stall` high until inst_valid at N+8.
- **Flush:** assert if_flush in DATA, RDATA=32'hDEAD_BEEF -> no inst_valid; inst unchanged; the next request fetches normally.
- **Error response:** RRESP=2'b10 -> inst=32'h0000_0013; inst_valid and inst_err pulse together.
- **Reset:** assert rst while in ADDR -> next cycle ARVALID=0, RREADY=0, inst_valid=0, inst=32'h0000_0013, state IDLE.
- **`IFETCH_BUF_EN`:** refetch pc_word=14'h0004 after a successful fetch -> no ARVALID, inst_valid at N+1 with the same data; a different pc_word goes to the bus.

Source files
------------

// File: rtl/ifetch_axi_master.sv
// ifetch_axi_master
//
// Single-outstanding AXI4 read master sitting directly behind the IF stage.
// It takes the 14-bit instruction word address from IF, fetches one 32-bit
// word over AR/R, and hands it back with a one-cycle inst_valid pulse. While
// a fetch is in progress IF is held off through fetch_stall.
//
// Optional feature (compile-time macro IFETCH_BUF_EN):
//   Adds a one-entry buffer of {last word address, last instruction, valid}.
//   A request in IDLE that hits the buffer is answered one cycle later with
//   no bus traffic. The buffer is filled by every non-dropped OKAY response
//   and cleared only by reset. With the macro undefined every request goes
//   to the bus.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   pc_word          word address from IF
//   fetch_req        IF wants the instruction at pc_word
//   if_flush         discard any in-flight fetch
//   inst             fetched instruction, held until the next inst_valid
//   inst_valid       one-cycle pulse when inst is updated
//   inst_err         pulses with inst_valid when RRESP was not OKAY
//   fetch_stall      fetch_req & ~inst_valid
//   AR* / R*         AXI4 read address and read data channels

module ifetch_axi_master #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,  // must be 32
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  // IF side
  input  logic [13:0]           pc_word,
  input  logic                  fetch_req,
  input  logic                  if_flush,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  inst_err,
  output logic                  fetch_stall,
  // AXI read address channel
  output logic [ID_WIDTH-1:0]   ARID,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [3:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // AXI read data channel
  input  logic [ID_WIDTH-1:0]   RID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [DATA_WIDTH-1:0] NOP_INST = 'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic                    drop_reg, drop_next;
  logic [DATA_WIDTH-1:0]   inst_reg, inst_next;
  logic                    inst_valid_reg, inst_valid_next;
  logic                    inst_err_reg, inst_err_next;

  logic [ADDR_WIDTH-1:0]   pc_byte;
  logic                    accept;
  logic                    buf_hit;
  logic [DATA_WIDTH-1:0]   buf_inst;

  // Single beat, single ID, no checking of RID/RLAST: only one transaction
  // can ever be outstanding, so the response is unambiguous.
  logic unused_inputs;
  assign unused_inputs = ^{RID, RLAST};

  // Zero-extended byte offset of the requested word.
  always_comb begin
    pc_byte       = '0;
    pc_byte[15:0] = {pc_word, 2'b00};
  end

  // A request is not taken in the inst_valid cycle: IF is still presenting
  // the address it was just answered for and only advances next cycle.
  assign accept = fetch_req & ~if_flush & ~inst_valid_reg;

`ifdef IFETCH_BUF_EN
  logic                  buf_valid_reg;
  logic [13:0]           buf_pc_reg;
  logic [DATA_WIDTH-1:0] buf_inst_reg;
  logic [13:0]           req_pc_reg;
  logic                  buf_fill;

  assign buf_hit  = buf_valid_reg & (buf_pc_reg == pc_word);
  assign buf_inst = buf_inst_reg;

  // Same condition under which inst is loaded with RDATA below.
  assign buf_fill = (state_reg == DATA) & RVALID & ~drop_reg & ~if_flush &
                    (RRESP == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_reg <= 1'b0;
      buf_pc_reg    <= '0;
      buf_inst_reg  <= NOP_INST;
      req_pc_reg    <= '0;
    end else begin
      // Remember which word is on the bus so the response can be tagged.
      if ((state_reg == IDLE) && accept && !buf_hit) begin
        req_pc_reg <= pc_word;
      end
      if (buf_fill) begin
        buf_valid_reg <= 1'b1;
        buf_pc_reg    <= req_pc_reg;
        buf_inst_reg  <= RDATA;
      end
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_inst = NOP_INST;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      araddr_reg     <= BASE_ADDR;
      drop_reg       <= 1'b0;
      inst_reg       <= NOP_INST;
      inst_valid_reg <= 1'b0;
      inst_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      araddr_reg     <= araddr_next;
      drop_reg       <= drop_next;
      inst_reg       <= inst_next;
      inst_valid_reg <= inst_valid_next;
      inst_err_reg   <= inst_err_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next      = state_reg;
    araddr_next     = araddr_reg;
    drop_next       = drop_reg;
    inst_next       = inst_reg;
    inst_valid_next = 1'b0;
    inst_err_next   = 1'b0;
    ARVALID         = 1'b0;
    RREADY          = 1'b0;

    case (state_reg)
      IDLE: begin
        drop_next = 1'b0;
        if (accept) begin
          if (buf_hit) begin
            inst_next       = buf_inst;
            inst_valid_next = 1'b1;
          end else begin
            araddr_next = BASE_ADDR + pc_byte;
            state_next  = ADDR;
          end
        end
      end

      ADDR: begin
        // A flush cannot withdraw ARVALID; it only marks the data as dead.
        ARVALID = 1'b1;
        if (if_flush) begin
          drop_next = 1'b1;
        end
        if (ARREADY) begin
          state_next = DATA;
        end
      end

      DATA: begin
        RREADY = 1'b1;
        if (if_flush) begin
          drop_next = 1'b1;
        end
        if (RVALID) begin
          state_next = IDLE;
          drop_next  = 1'b0;
          // A flush arriving together with the data also kills it.
          if (!drop_reg && !if_flush) begin
            inst_valid_next = 1'b1;
            if (RRESP == 2'b00) begin
              inst_next = RDATA;
            end else begin
              inst_next     = NOP_INST;
              inst_err_next = 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign inst        = inst_reg;
  assign inst_valid  = inst_valid_reg;
  assign inst_err    = inst_err_reg;
  assign fetch_stall = fetch_req & ~inst_valid_reg;

  assign ARID    = '0;
  assign ARADDR  = araddr_reg;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;

endmodule

// File: tb/tb_ifetch_axi_master.sv
// Testbench for ifetch_axi_master: scenario tasks plus a randomized run,
// checked against a transaction-level model (expected latency from the wait
// counts, expected instruction from the response, one-entry buffer model).

module tb_ifetch_axi_master;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [13:0] pc_word;
  logic        fetch_req;
  logic        if_flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_err;
  logic        fetch_stall;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_inst;
  bit          m_buf_v;
  logic [13:0] m_buf_pc;
  logic [31:0] m_buf_inst;

  ifetch_axi_master dut (
    .clk(clk), .rst(rst),
    .pc_word(pc_word), .fetch_req(fetch_req), .if_flush(if_flush),
    .inst(inst), .inst_valid(inst_valid), .inst_err(inst_err),
    .fetch_stall(fetch_stall),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit predict_hit(input logic [13:0] pc);
    return BUF_EN && m_buf_v && (pc == m_buf_pc);
  endfunction

  function automatic logic [31:0] word_addr(input logic [13:0] pc);
    return 32'(pc) * 32'd4;
  endfunction

  task automatic model_update(input bit hit, input bit flushed, input logic [13:0] pc,
                              input logic [1:0] resp, input logic [31:0] data);
    if (hit) begin
      m_inst = m_buf_inst;
    end else if (!flushed) begin
      if (resp == 2'b00) begin
        m_inst     = data;
        m_buf_v    = 1'b1;
        m_buf_pc   = pc;
        m_buf_inst = data;
      end else begin
        m_inst = NOP;
      end
    end
  endtask

  // Drives one IF request plus a slave with the given wait counts; cycle 0
  // is the cycle in which fetch_req is first presented. Called at posedge+1.
  task automatic run_fetch(input logic [13:0] pc, input int ar_wait, input int r_wait,
                           input logic [1:0] resp, input logic [31:0] data, input int flush_cyc,
                           output int valid_cyc, output int pulses, output logic v_err,
                           output logic [31:0] addr, output int ar_cnt, output bit addr_stable,
                           output int stall_cnt, output bit timed_out, output bit r_done);
    bit ar_done;
    int ar_hs;
    bit done;
    int tail;
    valid_cyc = -1; pulses = 0; v_err = 1'b0; addr = '0; ar_cnt = 0;
    addr_stable = 1'b1; stall_cnt = 0; timed_out = 1'b0; r_done = 1'b0;
    ar_done = 1'b0; ar_hs = 0; done = 1'b0; tail = 0;
    pc_word   = pc;
    fetch_req = 1'b1;
    for (int c = 0; c <= 80; c++) begin
      if (valid_cyc >= 0) fetch_req = 1'b0;
      if_flush = (c == flush_cyc);
      if (c == flush_cyc) fetch_req = 1'b0;
      ARREADY = !ar_done && (c >= 1 + ar_wait);
      RVALID  = ar_done && !r_done && (c >= ar_hs + 1 + r_wait);
      RDATA   = RVALID ? data : $urandom;
      RRESP   = RVALID ? resp : 2'($urandom);
      @(negedge clk);
      if (fetch_stall) stall_cnt++;
      if (ARVALID) begin
        if (ar_cnt == 0) addr = ARADDR;
        else if (ARADDR !== addr) addr_stable = 1'b0;
        ar_cnt++;
      end
      if (ARVALID && ARREADY) begin ar_done = 1'b1; ar_hs = c; end
      if (RVALID && RREADY) r_done = 1'b1;
      if (inst_valid) begin
        pulses++;
        if (valid_cyc < 0) begin valid_cyc = c; v_err = inst_err; end
      end
      if (done) tail++;
      else if ((flush_cyc < 0 && valid_cyc >= 0) || (flush_cyc >= 0 && r_done)) done = 1'b1;
      if (tail == 2) break;
      if (c == 80) timed_out = 1'b1;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    fetch_req = 1'b0; if_flush = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
    $display("txn pc=%h aw=%0d rw=%0d resp=%0d flush=%0d valid_cyc=%0d pulses=%0d ar_cycles=%0d inst=%h",
             pc, ar_wait, r_wait, resp, flush_cyc, valid_cyc, pulses, ar_cnt, inst);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", ARVALID); end
    total++; if (RREADY !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b exp=0", RREADY); end
    total++; if (inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    total++; if (inst_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", inst_err); end
    total++; if (ARADDR !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h exp=0", ARADDR); end
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", fetch_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int vc, pu, ac, sc; logic ve; logic [31:0] ad; bit st, to, rd;
    fork
      begin
        // Constant AR fields observed while ARVALID is up.
        @(posedge ARVALID);
        @(negedge clk);
        total++; if (ARLEN !== 4'd0) begin bad++; $display("FAIL basic_arlen got=%0d exp=0", ARLEN); end
        total++; if (ARSIZE !== 3'd2) begin bad++; $display("FAIL basic_arsize got=%0d exp=2", ARSIZE); end
        total++; if (ARBURST !== 2'b01) begin bad++; $display("FAIL basic_arburst got=%0d exp=1", ARBURST); end
        total++; if (ARID !== 4'd0) begin bad++; $display("FAIL basic_arid got=%0d exp=0", ARID); end
      end
      run_fetch(14'h0004, 0, 0, 2'b00, 32'h0010_0093, -1, vc, pu, ve, ad, ac, st, sc, to, rd);
    join
    total++; if (to) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    total++; if (ad !== 32'h0000_0010) begin bad++; $display("FAIL basic_araddr got=%h exp=00000010", ad); end
    total++; if (vc !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", vc); end
    total++; if (pu !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", pu); end
    total++; if (inst !== 32'h0010_0093) begin bad++; $display("FAIL basic_inst got=%h exp=00100093", inst); end
    total++; if (ve !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", ve); end
    total++; if (ac !== 1) begin bad++; $display("FAIL basic_ar_cycles got=%0d exp=1", ac); end
    total++; if (sc !== 3) begin bad++; $display("FAIL basic_stall_cycles got=%0d exp=3", sc); end
    model_update(1'b0, 1'b0, 14'h0004, 2'b00, 32'h0010_0093);
  endtask

  task automatic test_backpressure();
    int vc, pu, ac, sc; logic ve; logic [31:0] ad; bit st, to, rd;
    logic [31:0] d;
    d = $urandom;
    run_fetch(14'h0123, 3, 2, 2'b00, d, -1, vc, pu, ve, ad, ac, st, sc, to, rd);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
    total++; if (vc !== 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", vc); end
    total++; if (ac !== 4) begin bad++; $display("FAIL bp_ar_cycles got=%0d exp=4", ac); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL bp_addr_stable got=0 exp=1"); end
    total++; if (ad !== 32'h0000_048C) begin bad++; $display("FAIL bp_araddr got=%h exp=0000048c", ad); end
    total++; if (sc !== 8) begin bad++; $display("FAIL bp_stall_cycles got=%0d exp=8", sc); end
    total++; if (inst !== d) begin bad++; $display("FAIL bp_inst got=%h exp=%h", inst, d); end
    model_update(1'b0, 1'b0, 14'h0123, 2'b00, d);
  endtask

  task automatic test_flush();
    int vc, pu, ac, sc; logic ve; logic [31:0] ad; bit st, to, rd;
    logic [31:0] d;
    run_fetch(14'h0008, 0, 2, 2'b00, 32'hDEAD_BEEF, 2, vc, pu, ve, ad, ac, st, sc, to, rd);
    total++; if (pu !== 0) begin bad++; $display("FAIL flush_pulses got=%0d exp=0", pu); end
    total++; if (inst !== m_inst) begin bad++; $display("FAIL flush_inst got=%h exp=%h", inst, m_inst); end
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL flush_r_completed got=%b exp=1", rd); end
    model_update(1'b0, 1'b1, 14'h0008, 2'b00, 32'hDEAD_BEEF);
    d = $urandom;
    run_fetch(14'h0020, 0, 0, 2'b00, d, -1, vc, pu, ve, ad, ac, st, sc, to, rd);
    total++; if (vc !== 3) begin bad++; $display("FAIL flush_next_latency got=%0d exp=3", vc); end
    total++; if (inst !== d) begin bad++; $display("FAIL flush_next_inst got=%h exp=%h", inst, d); end
    total++; if (ad !== 32'h0000_0080) begin bad++; $display("FAIL flush_next_araddr got=%h exp=00000080", ad); end
    model_update(1'b0, 1'b0, 14'h0020, 2'b00, d);
  endtask

  task automatic test_error();
    int vc, pu, ac, sc; logic ve; logic [31:0] ad; bit st, to, rd;
    run_fetch(14'h0040, 1, 1, 2'b10, 32'h1234_5678, -1, vc, pu, ve, ad, ac, st, sc, to, rd);
    total++; if (vc !== 5) begin bad++; $display("FAIL err_latency got=%0d exp=5", vc); end
    total++; if (ve !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", ve); end
    total++; if (pu !== 1) begin bad++; $display("FAIL err_pulses got=%0d exp=1", pu); end
    total++; if (inst !== NOP) begin bad++; $display("FAIL err_inst got=%h exp=%h", inst, NOP); end
    model_update(1'b0, 1'b0, 14'h0040, 2'b10, 32'h1234_5678);
  endtask

  task automatic test_refetch();
    int vc, pu, ac, sc; logic ve; logic [31:0] ad; bit st, to, rd;
    // Buffer currently holds word 0x20, so word 4 goes to the bus first.
    run_fetch(14'h0004, 0, 0, 2'b00, 32'h0010_0093, -1, vc, pu, ve, ad, ac, st, sc, to, rd);
    total++; if (ac !== 1) begin bad++; $display("FAIL refetch_first_ar got=%0d exp=1", ac); end
    model_update(1'b0, 1'b0, 14'h0004, 2'b00, 32'h0010_0093);
    run_fetch(14'h0004, 0, 0, 2'b00, 32'hBAD0_0001, -1, vc, pu, ve, ad, ac, st, sc, to, rd);
    total++; if (ac !== (BUF_EN ? 0 : 1)) begin bad++; $display("FAIL refetch_ar_cycles got=%0d exp=%0d", ac, BUF_EN ? 0 : 1); end
    total++; if (vc !== (BUF_EN ? 1 : 3)) begin bad++; $display("FAIL refetch_latency got=%0d exp=%0d", vc, BUF_EN ? 1 : 3); end
    total++; if (inst !== (BUF_EN ? 32'h0010_0093 : 32'hBAD0_0001)) begin
      bad++; $display("FAIL refetch_inst got=%h exp=%h", inst, BUF_EN ? 32'h0010_0093 : 32'hBAD0_0001);
    end
    model_update(BUF_EN, 1'b0, 14'h0004, 2'b00, 32'hBAD0_0001);
    run_fetch(14'h0005, 0, 0, 2'b00, 32'h0020_0113, -1, vc, pu, ve, ad, ac, st, sc, to, rd);
    total++; if (ac !== 1) begin bad++; $display("FAIL refetch_other_ar got=%0d exp=1", ac); end
    total++; if (inst !== 32'h0020_0113) begin bad++; $display("FAIL refetch_other_inst got=%h exp=00200113", inst); end
    model_update(1'b0, 1'b0, 14'h0005, 2'b00, 32'h0020_0113);
  endtask

  task automatic test_reset_mid();
    pc_word = 14'h3FFF; fetch_req = 1'b1; ARREADY = 1'b0; RVALID = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ARVALID !== 1'b1) begin bad++; $display("FAIL rstmid_arvalid_before got=%b exp=1", ARVALID); end
    @(posedge clk); #1;
    rst = 1'b1; fetch_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL rstmid_arvalid got=%b exp=0", ARVALID); end
    total++; if (RREADY !== 1'b0) begin bad++; $display("FAIL rstmid_rready got=%b exp=0", RREADY); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", inst_valid); end
    total++; if (inst !== NOP) begin bad++; $display("FAIL rstmid_inst got=%h exp=%h", inst, NOP); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", ARVALID); end
    @(posedge clk); #1;
    m_inst = NOP; m_buf_v = 1'b0;
    $display("txn reset during ADDR");
  endtask

  task automatic test_random();
    int vc, pu, ac, sc; logic ve; logic [31:0] ad; bit st, to, rd;
    logic [13:0] pc; int aw, rw, fc; logic [1:0] resp; logic [31:0] d;
    bit hit, fl;
    int e_valid, e_ar; logic [31:0] e_inst; logic e_err;
    for (int t = 0; t < 40; t++) begin
      pc   = 14'(14'h100 + 14'($urandom_range(0, 3)) * 14'd5);
      aw   = $urandom_range(0, 3);
      rw   = $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d    = $urandom;
      hit  = predict_hit(pc);
      fc   = (!hit && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2 + aw + rw)) : -1;
      fl   = (fc >= 0);
      e_valid = hit ? 1 : (fl ? -1 : 3 + aw + rw);
      e_ar    = hit ? 0 : 1 + aw;
      e_inst  = hit ? m_buf_inst : (fl ? m_inst : ((resp == 2'b00) ? d : NOP));
      e_err   = !hit && !fl && (resp != 2'b00);
      run_fetch(pc, aw, rw, resp, d, fc, vc, pu, ve, ad, ac, st, sc, to, rd);
      total++; if (to) begin bad++; $display("FAIL rnd%0d_timeout got=1 exp=0", t); end
      total++; if (vc !== e_valid) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, vc, e_valid); end
      total++; if (pu !== (fl ? 0 : 1)) begin bad++; $display("FAIL rnd%0d_pulses got=%0d exp=%0d", t, pu, fl ? 0 : 1); end
      total++; if (inst !== e_inst) begin bad++; $display("FAIL rnd%0d_inst got=%h exp=%h", t, inst, e_inst); end
      total++; if (ve !== e_err) begin bad++; $display("FAIL rnd%0d_err got=%b exp=%b", t, ve, e_err); end
      total++; if (ac !== e_ar) begin bad++; $display("FAIL rnd%0d_ar_cycles got=%0d exp=%0d", t, ac, e_ar); end
      if (!hit) begin
        total++; if (ad !== word_addr(pc) || !st) begin
          bad++; $display("FAIL rnd%0d_araddr got=%h stable=%b exp=%h", t, ad, st, word_addr(pc));
        end
      end
      if (!fl) begin
        total++; if (sc !== e_valid) begin bad++; $display("FAIL rnd%0d_stall_cycles got=%0d exp=%0d", t, sc, e_valid); end
      end
      model_update(hit, fl, pc, resp, d);
    end
  endtask

  initial begin
    rst = 1'b1; pc_word = '0; fetch_req = 1'b0; if_flush = 1'b0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b1; RVALID = 1'b0;
    m_inst = NOP; m_buf_v = 1'b0; m_buf_pc = '0; m_buf_inst = NOP;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_error();
    test_refetch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
